// File: rtl/core_uart_apb_pkg.sv
// Shared definitions for core_uart_apb: APB register offsets, parity encoding,
// transmit/receive state enums and small parity/format helpers.
package core_uart_apb_pkg;

    localparam logic [4:0] AddrTxdata = 5'h00;
    localparam logic [4:0] AddrRxdata = 5'h04;
    localparam logic [4:0] AddrCtrl1  = 5'h08;
    localparam logic [4:0] AddrCtrl2  = 5'h0C;
    localparam logic [4:0] AddrStatus = 5'h10;
    localparam logic [4:0] AddrCtrl3  = 5'h14;

    typedef enum logic [1:0] {
        ParNone = 2'd0,
        ParEven = 2'd1,
        ParOdd  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TxIdle, TxStart, TxData, TxParity, TxStop
    } tx_state_e;

    typedef enum logic [2:0] {
        RxHunt, RxStart, RxData, RxParity, RxStop, RxDelay, RxWaitHigh
    } rx_state_e;

    // Parity bit that makes the frame's count of ones even (odd=0) or odd (odd=1).
    function automatic logic parity_bit(input logic [7:0] data, input logic bit8,
                                        input logic odd);
        return (^(bit8 ? data : {1'b0, data[6:0]})) ^ odd;
    endfunction

    // Index of the last data bit for the selected width.
    function automatic logic [2:0] last_bit(input logic bit8);
        return bit8 ? 3'd7 : 3'd6;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// x16 oversampling tick generator.
// Ports: clk, rst (async, active-high); baud = divisor (period baud+1 clocks);
// frctn/frctn_en = fractional eighths; tick = one-clock pulse per oversample period.
module uart_baud_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] baud,
    input  logic [2:0]  frctn,
    input  logic        frctn_en,
    output logic        tick
);

    logic [12:0] cnt_q;
    logic [2:0]  idx_q;
    logic        ext_q;
    logic        stretch;

    // The first frctn ticks of every group of eight hold at zero for one extra clock.
    assign stretch = frctn_en && (idx_q < frctn) && !ext_q;
    assign tick    = (cnt_q == 13'd0) && !stretch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            ext_q <= 1'b0;
        end else if (cnt_q == 13'd0) begin
            if (stretch) begin
                ext_q <= 1'b1;
            end else begin
                cnt_q <= baud;
                idx_q <= idx_q + 3'd1;
                ext_q <= 1'b0;
            end
        end else begin
            cnt_q <= cnt_q - 13'd1;
        end
    end

endmodule

// File: rtl/core_uart_apb.sv
// APB3 slave UART with single-byte TX/RX holding registers, programmable baud,
// parity/framing/overflow detection.
// Ports: PCLK, PRESETN (async, active-high); APB PSEL/PENABLE/PWRITE/PADDR/PWDATA,
// PRDATA (combinational), PREADY=1, PSLVERR=0; registered status flags
// TXRDY/RXRDY/PARITY_ERR/FRAMING_ERR/OVERFLOW; serial RX in, TX out (idles high).
module core_uart_apb import core_uart_apb_pkg::*; #(
    parameter int unsigned BAUD_VALUE        = 1,
    parameter int unsigned BAUD_VAL_FRCTN    = 0,
    parameter int unsigned BAUD_VAL_FRCTN_EN = 0,
    parameter int unsigned FIXEDMODE         = 0,
    parameter int unsigned PRG_BIT8          = 1,
    parameter int unsigned PRG_PARITY        = 0,
    parameter int unsigned RX_LEGACY_MODE    = 0
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [4:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR,
    output logic       TXRDY,
    output logic       RXRDY,
    output logic       PARITY_ERR,
    output logic       FRAMING_ERR,
    output logic       OVERFLOW,
    input  logic       RX,
    output logic       TX
);

    localparam logic [12:0] BaudInit  = 13'(BAUD_VALUE);
    localparam logic [2:0]  FrctnInit = 3'(BAUD_VAL_FRCTN);
    localparam logic        Bit8Init  = (PRG_BIT8 != 0);
    localparam logic        ParInit   = (PRG_PARITY != 0);
    localparam logic        OddInit   = (PRG_PARITY == 32'(ParOdd));
    localparam logic        Fixed     = (FIXEDMODE != 0);

    logic        wr_en, rd_en, rd_rx, tick, frctn_en;
    logic [12:0] baud_q, baud_eff;
    logic [2:0]  frctn_q, frctn_eff;
    logic        bit8_q, par_en_q, odd_q, bit8_eff, par_en_eff, odd_eff;

    tx_state_e   tx_state_q, tx_state_d;
    logic [3:0]  tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_data_q, tx_data_d, hold_q, hold_d;
    logic        tx_bit8_q, tx_bit8_d, tx_par_en_q, tx_par_en_d, tx_par_q, tx_par_d;
    logic        tx_q, tx_d, txrdy_q, txrdy_d;

    rx_state_e   rx_state_q, rx_state_d;
    logic [3:0]  rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d, rxdata_q, rxdata_d;
    logic        rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d, commit;
    logic        rx_m_q, rx_s, rx_prev_q;
    logic        rxrdy_q, rxrdy_d, perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;

    assign wr_en  = PSEL & PENABLE & PWRITE;
    assign rd_en  = PSEL & PENABLE & ~PWRITE;
    assign rd_rx  = rd_en && (PADDR == AddrRxdata);

    assign baud_eff   = Fixed ? BaudInit  : baud_q;
    assign frctn_eff  = Fixed ? FrctnInit : frctn_q;
    assign bit8_eff   = Fixed ? Bit8Init  : bit8_q;
    assign par_en_eff = Fixed ? ParInit   : par_en_q;
    assign odd_eff    = Fixed ? OddInit   : odd_q;
    assign frctn_en   = (BAUD_VAL_FRCTN_EN != 0);

    uart_baud_gen u_baud_gen (
        .clk      (PCLK),
        .rst      (PRESETN),
        .baud     (baud_eff),
        .frctn    (frctn_eff),
        .frctn_en (frctn_en),
        .tick     (tick)
    );

    // Transmitter: loads the holding byte on a tick so every bit lasts exactly 16 ticks.
    // The frame format is latched at load so later CTRL writes do not corrupt it.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_data_d   = tx_data_q;
        tx_bit8_d   = tx_bit8_q;
        tx_par_en_d = tx_par_en_q;
        tx_par_d    = tx_par_q;
        tx_d        = tx_q;
        hold_d      = hold_q;
        txrdy_d     = txrdy_q;
        if (wr_en && (PADDR == AddrTxdata) && txrdy_q) begin
            hold_d  = PWDATA;
            txrdy_d = 1'b0;
        end
        if (tick) begin
            tx_cnt_d = tx_cnt_q + 4'd1;
            unique case (tx_state_q)
                TxIdle: begin
                    tx_cnt_d = '0;
                    if (!txrdy_q) begin
                        tx_data_d   = hold_q;
                        txrdy_d     = 1'b1;
                        tx_bit8_d   = bit8_eff;
                        tx_par_en_d = par_en_eff;
                        tx_par_d    = parity_bit(hold_q, bit8_eff, odd_eff);
                        tx_state_d  = TxStart;
                        tx_d        = 1'b0;
                    end
                end
                TxStart: if (tx_cnt_q == 4'd15) begin
                    tx_state_d = TxData;
                    tx_bit_d   = '0;
                    tx_d       = tx_data_q[0];
                end
                TxData: if (tx_cnt_q == 4'd15) begin
                    if (tx_bit_q == last_bit(tx_bit8_q)) begin
                        tx_state_d = tx_par_en_q ? TxParity : TxStop;
                        tx_d       = tx_par_en_q ? tx_par_q : 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_d     = tx_data_q[tx_bit_d];
                    end
                end
                TxParity: if (tx_cnt_q == 4'd15) begin
                    tx_state_d = TxStop;
                    tx_d       = 1'b1;
                end
                TxStop: if (tx_cnt_q == 4'd15) begin
                    tx_state_d = TxIdle;
                    tx_d       = 1'b1;
                end
                default: tx_state_d = TxIdle;
            endcase
        end
    end

    // Receiver: start bit verified at tick 8, then one sample per 16 ticks.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = tick ? rx_cnt_q + 4'd1 : rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        commit     = 1'b0;
        unique case (rx_state_q)
            RxHunt: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s) rx_state_d = RxStart;
            end
            RxStart: if (tick && rx_cnt_q == 4'd7) begin
                rx_cnt_d = '0;
                if (rx_s) begin
                    rx_state_d = RxHunt;
                end else begin
                    rx_state_d = RxData;
                    rx_bit_d   = '0;
                    rx_shift_d = '0;
                    rx_perr_d  = 1'b0;
                    rx_ferr_d  = 1'b0;
                end
            end
            RxData: if (tick && rx_cnt_q == 4'd15) begin
                rx_shift_d[rx_bit_q] = rx_s;
                if (rx_bit_q == last_bit(bit8_eff)) begin
                    rx_state_d = par_en_eff ? RxParity : RxStop;
                end else begin
                    rx_bit_d = rx_bit_q + 3'd1;
                end
            end
            RxParity: if (tick && rx_cnt_q == 4'd15) begin
                rx_perr_d  = rx_s != parity_bit(rx_shift_q, bit8_eff, odd_eff);
                rx_state_d = RxStop;
            end
            RxStop: if (tick && rx_cnt_q == 4'd15) begin
                rx_ferr_d = !rx_s;
                if (RX_LEGACY_MODE != 0) begin
                    rx_state_d = RxDelay;
                end else begin
                    commit     = 1'b1;
                    rx_state_d = rx_s ? RxHunt : RxWaitHigh;
                end
            end
            RxDelay: if (tick && rx_cnt_q == 4'd7) begin
                commit     = 1'b1;
                rx_state_d = rx_ferr_q ? RxWaitHigh : RxHunt;
            end
            RxWaitHigh: if (rx_s) rx_state_d = RxHunt;
            default: rx_state_d = RxHunt;
        endcase
    end

    // Status flags: an RXDATA read clears them; a set in the same cycle wins.
    always_comb begin
        rxrdy_d  = rxrdy_q & ~rd_rx;
        perr_d   = perr_q & ~rd_rx;
        ferr_d   = ferr_q & ~rd_rx;
        ovf_d    = ovf_q & ~rd_rx;
        rxdata_d = rxdata_q;
        if (commit) begin
            if (rxrdy_q) begin
                ovf_d = 1'b1;
            end else begin
                rxdata_d = rx_shift_d;
                rxrdy_d  = 1'b1;
                perr_d   = perr_d | rx_perr_d;
                ferr_d   = ferr_d | rx_ferr_d;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESETN) begin
        if (PRESETN) begin
            baud_q      <= BaudInit;
            frctn_q     <= FrctnInit;
            bit8_q      <= Bit8Init;
            par_en_q    <= ParInit;
            odd_q       <= OddInit;
            tx_state_q  <= TxIdle;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_data_q   <= '0;
            tx_bit8_q   <= 1'b1;
            tx_par_en_q <= 1'b0;
            tx_par_q    <= 1'b0;
            tx_q        <= 1'b1;
            hold_q      <= '0;
            txrdy_q     <= 1'b1;
            rx_state_q  <= RxHunt;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_perr_q   <= 1'b0;
            rx_ferr_q   <= 1'b0;
            rx_m_q      <= 1'b1;
            rx_s        <= 1'b1;
            rx_prev_q   <= 1'b1;
            rxdata_q    <= '0;
            rxrdy_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (wr_en) begin
                case (PADDR)
                    AddrCtrl1: baud_q[7:0] <= PWDATA;
                    AddrCtrl2: begin
                        baud_q[12:8] <= PWDATA[7:3];
                        odd_q        <= PWDATA[2];
                        par_en_q     <= PWDATA[1];
                        bit8_q       <= PWDATA[0];
                    end
                    AddrCtrl3: frctn_q <= PWDATA[2:0];
                    default: ;
                endcase
            end
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_data_q   <= tx_data_d;
            tx_bit8_q   <= tx_bit8_d;
            tx_par_en_q <= tx_par_en_d;
            tx_par_q    <= tx_par_d;
            tx_q        <= tx_d;
            hold_q      <= hold_d;
            txrdy_q     <= txrdy_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_perr_q   <= rx_perr_d;
            rx_ferr_q   <= rx_ferr_d;
            rx_m_q      <= RX;
            rx_s        <= rx_m_q;
            rx_prev_q   <= rx_s;
            rxdata_q    <= rxdata_d;
            rxrdy_q     <= rxrdy_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            case (PADDR)
                AddrRxdata: PRDATA = rxdata_q;
                AddrCtrl1:  PRDATA = Fixed ? 8'h00 : baud_q[7:0];
                AddrCtrl2:  PRDATA = Fixed ? 8'h00 : {baud_q[12:8], odd_q, par_en_q, bit8_q};
                AddrStatus: PRDATA = {3'b0, ferr_q, ovf_q, perr_q, rxrdy_q, txrdy_q};
                AddrCtrl3:  PRDATA = Fixed ? 8'h00 : {5'b0, frctn_q};
                default:    PRDATA = '0;
            endcase
        end
    end

    assign PREADY      = 1'b1;
    assign PSLVERR     = 1'b0;
    assign TX          = tx_q;
    assign TXRDY       = txrdy_q;
    assign RXRDY       = rxrdy_q;
    assign PARITY_ERR  = perr_q;
    assign FRAMING_ERR = ferr_q;
    assign OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_core_uart_apb.sv
// Directed + randomized bench for core_uart_apb at BAUD_VALUE=1 (32 PCLK per bit).
module tb_core_uart_apb;

    localparam int Baud      = 1;
    localparam int BitCycles = 16 * (Baud + 1);

    logic       clk, rst, psel, penable, pwrite;
    logic [4:0] paddr;
    logic [7:0] pwdata, prdata, rd;
    logic       pready, pslverr, txrdy, rxrdy, par_err, frm_err, ovf, rx, tx;
    logic       loop, rx_drv;
    int         total, bad;

    assign rx = loop ? tx : rx_drv;

    core_uart_apb #(.BAUD_VALUE(Baud)) dut (
        .PCLK(clk), .PRESETN(rst), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
        .TXRDY(txrdy), .RXRDY(rxrdy), .PARITY_ERR(par_err), .FRAMING_ERR(frm_err),
        .OVERFLOW(ovf), .RX(rx), .TX(tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk); penable = 1'b1;
        @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [7:0] d);
        @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk); penable = 1'b1; #1 d = prdata;
        @(negedge clk); psel = 1'b0; penable = 1'b0;
    endtask

    task automatic read_check(input logic [4:0] a, input logic [7:0] exp, input string tag);
        logic [7:0] d;
        apb_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic wait_rxrdy(input int budget, input string tag);
        int n;
        n = 0;
        while (rxrdy !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        check(tag, rxrdy, 1);
    endtask

    // Reference frame: start, data LSB first, optional parity (1=even, 2=odd), stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bit8,
                                               input int par);
        logic [10:0] f;
        int n, ones;
        f = '0; n = 1; ones = 0;
        for (int i = 0; i < (bit8 ? 8 : 7); i++) begin f[n] = b[i]; ones += int'(b[i]); n++; end
        if (par != 0) begin f[n] = ((ones % 2) == 1) ^ (par == 2); n++; end
        f[n] = 1'b1;
        return f;
    endfunction

    task automatic drive_frame(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin rx_drv = f[i]; repeat (BitCycles) @(negedge clk); end
        rx_drv = 1'b1;
    endtask

    // Samples TX mid-bit after the next falling edge.
    task automatic capture_tx(input int nbits, output logic [10:0] f);
        int n;
        f = '0; n = 0;
        while (tx !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        if (tx === 1'b0) begin
            repeat (BitCycles / 2) @(negedge clk);
            for (int i = 0; i < nbits; i++) begin
                f[i] = tx;
                if (i < nbits - 1) repeat (BitCycles) @(negedge clk);
            end
        end else begin
            f = 11'h7ff;
        end
    endtask

    initial begin
        logic [7:0]  b;
        logic [10:0] f, got;
        int          n, p, nb;
        bit          b8;
        total = 0; bad = 0;
        rst = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = 5'h10; pwdata = 0;
        loop = 1'b0; rx_drv = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_txrdy", txrdy, 1);
        check("reset_flags", {rxrdy, par_err, frm_err, ovf}, 0);
        check("prdata_idle", prdata, 0);
        check("pready_pslverr", {pready, pslverr}, 2'b10);
        rst = 1'b0;
        read_check(5'h10, 8'h01, "reset_status");
        read_check(5'h08, 8'h01, "reset_ctrl1");
        read_check(5'h0C, 8'h01, "reset_ctrl2");
        read_check(5'h1C, 8'h00, "unmapped");

        // Loopback 8N1, 0x55
        loop = 1'b1;
        apb_write(5'h00, 8'h55);
        check("txrdy_low_after_write", txrdy, 0);
        n = 0;
        while (tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        check("start_edge_seen", tx, 0);
        n = 0;
        while (tx === 1'b0 && n < 100) begin @(negedge clk); n++; end
        check("start_bit_width", 16'(n), 16'(BitCycles));
        wait_rxrdy(400, "loop55_rxrdy");
        read_check(5'h04, 8'h55, "loop55_rxdata");
        read_check(5'h10, 8'h01, "loop55_cleared");

        // Randomized formats in loopback: TX bit stream and received byte vs model
        for (int it = 0; it < 6; it++) begin
            b = 8'($urandom_range(0, 255));
            b8 = 1'($urandom_range(0, 1));
            p = int'($urandom_range(0, 2));
            nb = 2 + (b8 ? 8 : 7) + (p != 0 ? 1 : 0);
            apb_write(5'h0C, {5'b0, p == 2, p != 0, b8});
            apb_write(5'h00, b);
            capture_tx(nb, got);
            check("rand_tx_frame", got, frame_bits(b, b8, p));
            wait_rxrdy(100, "rand_rxrdy");
            read_check(5'h10, 8'h03, "rand_status");
            read_check(5'h04, b8 ? b : {1'b0, b[6:0]}, "rand_rxdata");
        end

        // Parity error: even-parity frame into an odd-parity receiver
        loop = 1'b0;
        repeat (BitCycles) @(negedge clk);
        apb_write(5'h0C, 8'h07);
        drive_frame(frame_bits(8'hA7, 1'b1, 1), 11);
        wait_rxrdy(100, "par_rxrdy");
        check("par_err_out", par_err, 1);
        read_check(5'h10, 8'h07, "par_status");
        read_check(5'h04, 8'hA7, "par_rxdata");
        read_check(5'h10, 8'h01, "par_cleared");

        // Overflow: two frames without reading
        apb_write(5'h0C, 8'h01);
        drive_frame(frame_bits(8'h3C, 1'b1, 0), 10);
        drive_frame(frame_bits(8'hC3, 1'b1, 0), 10);
        repeat (4) @(negedge clk);
        check("ovf_out", ovf, 1);
        read_check(5'h10, 8'h0B, "ovf_status");
        read_check(5'h04, 8'h3C, "ovf_rxdata");
        read_check(5'h10, 8'h01, "ovf_cleared");

        // Framing: line held low for two frame times
        rx_drv = 1'b0;
        repeat (2 * 10 * BitCycles) @(negedge clk);
        check("frm_out", frm_err, 1);
        read_check(5'h10, 8'h13, "frm_status");
        read_check(5'h04, 8'h00, "frm_rxdata");
        repeat (12 * BitCycles) @(negedge clk);
        check("frm_no_new_frame_low", rxrdy, 0);
        rx_drv = 1'b1;
        repeat (12 * BitCycles) @(negedge clk);
        check("frm_no_new_frame_high", rxrdy, 0);
        drive_frame(frame_bits(8'h5A, 1'b1, 0), 10);
        wait_rxrdy(100, "frm_recover_rxrdy");
        read_check(5'h04, 8'h5A, "frm_recover_rxdata");

        // Back-to-back writes, third dropped
        loop = 1'b1;
        apb_write(5'h00, 8'h11);
        n = 0;
        while (txrdy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("b2b_first_taken", txrdy, 1);
        apb_write(5'h00, 8'h22);
        check("b2b_txrdy_low", txrdy, 0);
        apb_write(5'h00, 8'h33);
        check("b2b_still_busy", txrdy, 0);
        wait_rxrdy(700, "b2b_rxrdy1");
        read_check(5'h04, 8'h11, "b2b_byte1");
        wait_rxrdy(400, "b2b_rxrdy2");
        read_check(5'h04, 8'h22, "b2b_byte2");
        repeat (14 * BitCycles) @(negedge clk);
        check("b2b_third_dropped", {rxrdy, txrdy, tx}, 3'b011);

        // Reset mid-frame
        apb_write(5'h00, 8'h00);
        n = 0;
        while (tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        repeat (40) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_tx", tx, 1);
        check("midreset_txrdy", txrdy, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12 * BitCycles) @(negedge clk);
        check("midreset_idle", {tx, rxrdy}, 2'b10);
        read_check(5'h10, 8'h01, "midreset_status");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_uart_apb.md
# core_uart_apb

APB3-slave UART with single-byte transmit and receive holding registers, a programmable 16x-oversampling baud generator, and framing, parity and overflow detection. It sits on the peripheral APB bus behind the subsystem decoder. TX/RX connect to pins or to another UART instance. Status flags are exported as discrete outputs for interrupt logic.

## Interface
- BAUD_VALUE, 1: 13-bit baud divisor; tick period = BAUD_VALUE+1 PCLK.
- BAUD_VAL_FRCTN, 0: 3-bit fractional divisor, in eighths.
- BAUD_VAL_FRCTN_EN, 0: 1 enables the fractional divisor.
- FIXEDMODE, 0: 1 = format and baud come from parameters; control registers are ignored and read 0.
- PRG_BIT8, 1: fixed-mode data width; 1 = 8 bits, 0 = 7 bits.
- PRG_PARITY, 0: fixed-mode parity; 0 = none, 1 = even, 2 = odd.
- RX_LEGACY_MODE, 0: 1 delays the RX update by 8 ticks (see Operation).
- PCLK  in  1  clock; the only clock.
- PRESETN  in  1  reset; one clock; reset is asynchronous and active-high (1 = reset).
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PADDR  in  5  byte address.
- PWDATA  in  8  write data.
- PRDATA  out  8  read data.
- PREADY  out  1  tied 1.
- PSLVERR  out  1  tied 0.
- TXRDY, RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW  out  1 each  status flags.
- RX  in  1  serial input, asynchronous.
- TX  out  1  serial output; idles high.

## Operation
- Register writes occur on PSEL & PENABLE & PWRITE.
- Read side effects occur on PSEL & PENABLE & !PWRITE.
- PRDATA is combinational. It is 0 when PSEL=0 or the address is unmapped.
- Register map:
  - 0x00 TXDATA (write only).
  - 0x04 RXDATA (read only).
  - 0x08 CTRL1 = baud[7:0].
  - 0x0C CTRL2 = {baud[12:8], odd, parity_en, bit8}.
  - 0x10 STATUS = {3'b0, FRAMING_ERR, OVERFLOW, PARITY_ERR, RXRDY, TXRDY}.
  - 0x14 CTRL3 = {5'b0, frctn[2:0]}.
- Control register reset values are derived from the parameters.
- Baud generator:
  - Down-counter reloads with baud and emits a 1-PCLK tick at 0.
  - With fraction enabled, in each group of 8 ticks the first frctn ticks last one extra PCLK.
- Frame: start bit (0), 7 or 8 data bits LSB first, optional parity bit, 1 stop bit (1). Each bit lasts 16 ticks.
- TX:
  - A TXDATA write with TXRDY=1 loads the holding register and clears TXRDY.
  - A TXDATA write with TXRDY=0 is ignored.
  - The idle shifter takes the holding byte and sets TXRDY.
  - TX states: IDLE, START, DATA, PARITY, STOP.
- RX:
  - RX is synchronized with 2 flops.
  - A falling edge starts a frame; the line is re-checked at tick 8.
  - If the line is high at tick 8, the start bit is false and the receiver returns to hunting.
  - Data is sampled every 16 ticks thereafter.
  - Stop bit sampled 0: store the byte, set FRAMING_ERR, then wait for RX high before hunting again.
  - Parity mismatch sets PARITY_ERR.
  - In 7-bit mode RXDATA[7] = 0.
- RX update: with RX_LEGACY_MODE=0, RXDATA and RXRDY update at the stop-bit sample; with 1, they update 8 ticks later.
- Overflow: a frame that completes while RXRDY=1 sets OVERFLOW, and the new byte is discarded.
- An RXDATA read clears RXRDY, PARITY_ERR, OVERFLOW and FRAMING_ERR. Flag set and clear in the same cycle: set wins.

## Timing
- Reset values:
  - TX=1, TXRDY=1.
  - RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW = 0.
  - PRDATA=0.
- TXDATA write → TXRDY low on the next PCLK edge.
- TX start edge follows within one tick period + 2 PCLK.
- Frame length = (2 + data + parity) × 16 × (baud+1) PCLK.
- Status outputs are registered; RXRDY rises 1 PCLK after the deciding sample.
- Reset mid-frame aborts both shifters immediately.

## Structure
- Shared package contains: register offsets, the parity encoding (NONE/EVEN/ODD), and the TX/RX state enums.
- Natural sub-module: uart_baud_gen (divisor plus fraction, emits the x16 tick).
- TX and RX shifters live in core_uart_apb.

## Test plan
- Reset → TX=1, TXRDY=1, STATUS reads 0x01, other flags 0.
- BAUD_VALUE=1, 8N1, TX looped to RX:
  - Write 0x55 → TXRDY low next cycle; TX start bit 32 PCLK wide.
  - RX side RXRDY=1 ~320 PCLK later; RXDATA=0x55; the read clears RXRDY.
- FIXEDMODE=0, CTRL2=0x03 (8 data bits, even parity), send 0xA7, receiver set to odd parity → PARITY_ERR=1, RXDATA=0xA7.
- Send two bytes without reading → OVERFLOW=1, RXDATA holds the first byte; RXDATA read clears OVERFLOW.
- RX held 0 for 2 frames → FRAMING_ERR=1, RXDATA=0x00; no new frame until RX returns high.
- Two TXDATA writes back-to-back → both bytes sent in order; a third write while TXRDY=0 is dropped.
